mem_resp: RTL and testbench

MEM_RESP -- requirements
Module: mem_resp

---
 rtl/mem_resp_pkg.sv | 29 ++
 rtl/mem_resp_ram.sv | 32 +++
 rtl/mem_resp.sv | 170 +++++++++++++++++
 tb/tb_mem_resp.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg -- shared definitions for the mem_resp responder slice.
//   u1 / u32       : scalar and 32-bit word typedefs
//   state_t        : responder FSM states (IDLE, WAIT, RESP)
//   DEF_*          : default parameter values for mem_resp
//   CNT_W          : width of the wait-state counter (0..15)
//   req_is_err()   : request legality check (misaligned or write+fetch)
package mem_resp_pkg;

   typedef logic        u1;
   typedef logic [31:0] u32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int DEF_WAIT_CYCLES = 2;
   localparam int DEF_DEPTH_WORDS = 64;
   localparam int CNT_W           = 4;

   // A request is rejected when it is not word aligned or when it claims
   // to be both a write and an instruction fetch.
   function automatic u1 req_is_err(input u1 we, input u1 ifetch,
                                    input logic [1:0] lsb);
      return (lsb != 2'b00) || (we && ifetch);
   endfunction

endpackage

// File: rtl/mem_resp_ram.sv
// mem_resp_ram -- word array behind the mem_resp responder.
//   clk    : write clock
//   we     : write enable (commit on rising edge)
//   waddr  : write word index
//   wdata  : write data
//   raddr  : read word index
//   rdata  : combinational read data
// Contents are deliberately never reset.
module mem_resp_ram
   import mem_resp_pkg::*;
#(
   parameter int DEPTH_WORDS = DEF_DEPTH_WORDS
) (
   input  logic                           clk,
   input  logic                           we,
   input  logic [$clog2(DEPTH_WORDS)-1:0] waddr,
   input  logic [31:0]                    wdata,
   input  logic [$clog2(DEPTH_WORDS)-1:0] raddr,
   output logic [31:0]                    rdata
);

   u32 mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/mem_resp.sv
// mem_resp -- single-outstanding memory responder with programmable wait
// states, an instruction register and a data register.
//   clk         : clock, all state changes on rising edge
//   reset       : asynchronous active-low reset
//   req_valid   : request present          req_ready : accepting (IDLE only)
//   req_we      : word write               req_ifetch: instruction fetch
//   req_addr    : byte address             req_wdata : write data
//   resp_valid  : one-cycle completion pulse
//   resp_err    : completion is a rejection
//   resp_rdata  : read data (or written data for writes), 0 otherwise
//   instr       : last successful fetch    readdata  : last successful read
// Optional: define MEM_RESP_TRACE_EN to print one line per completed
// transaction (time, R/W/F, addr, data, err).
module mem_resp
   import mem_resp_pkg::*;
#(
   parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
   parameter int DEPTH_WORDS = DEF_DEPTH_WORDS
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic        req_ifetch,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic        resp_err,
   output logic [31:0] resp_rdata,
   output logic [31:0] instr,
   output logic [31:0] readdata
);

   localparam int AW = $clog2(DEPTH_WORDS);

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;

   u1                we_reg, ifetch_reg;
   u32               addr_reg, wdata_reg;
   u32               instr_reg, readdata_reg;

   u1                accept;
   u1                err;
   u1                commit;
   u1                ram_we;
   logic [AW-1:0]    idx;
   u32               ram_rdata;

   // Only the index bits of the latched address matter to the array;
   // higher bits are ignored so addresses wrap modulo DEPTH_WORDS*4.
   assign idx = addr_reg[AW+1:2];
   assign err = req_is_err(we_reg, ifetch_reg, addr_reg[1:0]);

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   // ---------------- next-state logic ----------------
   // The counter is loaded with WAIT_CYCLES on acceptance; the WAIT cycle in
   // which it reads 1 is the last one, giving exactly WAIT_CYCLES wait states.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      accept     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (req_valid) begin
               accept   = 1'b1;
               cnt_next = CNT_W'(WAIT_CYCLES);
               state_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
            end
         end
         WAIT: begin
            cnt_next = cnt_reg - 4'd1;
            if (cnt_reg == 4'd1) begin
               state_next = RESP;
            end
         end
         RESP: begin
            cnt_next   = '0;
            state_next = IDLE;
         end
         default: begin
            cnt_next   = '0;
            state_next = IDLE;
         end
      endcase
   end

   // ---------------- output logic ----------------
   always_comb begin
      req_ready  = (state_reg == IDLE);
      resp_valid = (state_reg == RESP);
      resp_err   = resp_valid && err;
      resp_rdata = '0;
      if (resp_valid && !err) begin
         resp_rdata = we_reg ? wdata_reg : ram_rdata;
      end
   end

   // Everything that completes a transaction happens on the edge ending RESP.
   // Because reset forces IDLE asynchronously, an aborted transaction never
   // reaches this edge and so never writes or updates a register.
   assign commit = (state_reg == RESP) && !err;
   assign ram_we = commit && we_reg;

   // ---------------- request latch and result registers ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         we_reg       <= 1'b0;
         ifetch_reg   <= 1'b0;
         addr_reg     <= '0;
         wdata_reg    <= '0;
         instr_reg    <= '0;
         readdata_reg <= '0;
      end else begin
         if (accept) begin
            we_reg     <= req_we;
            ifetch_reg <= req_ifetch;
            addr_reg   <= req_addr;
            wdata_reg  <= req_wdata;
         end
         if (commit && !we_reg) begin
            if (ifetch_reg) begin
               instr_reg <= resp_rdata;
            end else begin
               readdata_reg <= resp_rdata;
            end
         end
      end
   end

   assign instr    = instr_reg;
   assign readdata = readdata_reg;

   mem_resp_ram #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (idx),
      .wdata (wdata_reg),
      .raddr (idx),
      .rdata (ram_rdata)
   );

   // Upper address bits are kept for tracing only.
   logic unused_addr_hi;
   assign unused_addr_hi = ^addr_reg[31:AW+2];

`ifdef MEM_RESP_TRACE_EN
   always @(posedge clk) begin
      if (reset && state_reg == RESP) begin
         $display("%0t mem_resp %s addr=0x%08h data=0x%08h err=%0d",
                  $time, we_reg ? "W" : (ifetch_reg ? "F" : "R"),
                  addr_reg, resp_rdata, err);
      end
   end
`endif

endmodule

// File: tb/tb_mem_resp.sv
module tb_mem_resp;

   localparam int WA = 2;

   logic        clk;
   logic        rst_n;

   // instance A: WAIT_CYCLES=2, DEPTH_WORDS=64
   logic        req_valid, req_we, req_ifetch;
   logic [31:0] req_addr, req_wdata;
   logic        req_ready, resp_valid, resp_err;
   logic [31:0] resp_rdata, instr, readdata;

   // instance B: WAIT_CYCLES=0
   logic        b_valid, b_we, b_ifetch;
   logic [31:0] b_addr, b_wdata;
   logic        b_ready, b_resp_valid, b_resp_err;
   logic [31:0] b_resp_rdata, b_instr, b_readdata;

   int checks = 0;
   int errors = 0;

   mem_resp #(.WAIT_CYCLES(WA), .DEPTH_WORDS(64)) dut_a (
      .clk        (clk),
      .reset      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_ifetch (req_ifetch),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_err   (resp_err),
      .resp_rdata (resp_rdata),
      .instr      (instr),
      .readdata   (readdata)
   );

   mem_resp #(.WAIT_CYCLES(0), .DEPTH_WORDS(64)) dut_b (
      .clk        (clk),
      .reset      (rst_n),
      .req_valid  (b_valid),
      .req_ready  (b_ready),
      .req_we     (b_we),
      .req_ifetch (b_ifetch),
      .req_addr   (b_addr),
      .req_wdata  (b_wdata),
      .resp_valid (b_resp_valid),
      .resp_err   (b_resp_err),
      .resp_rdata (b_resp_rdata),
      .instr      (b_instr),
      .readdata   (b_readdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // One transaction on instance A: present at a falling edge, accept at the
   // next rising edge, then scramble the request inputs while waiting.
   task automatic txn(input string tag, input logic we, input logic ifetch,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic exp_err, input logic [31:0] exp_rdata);
      int  k;
      logic got;
      @(negedge clk);
      chk({tag, " ready"}, 32'(req_ready), 32'd1);
      req_valid  = 1'b1;
      req_we     = we;
      req_ifetch = ifetch;
      req_addr   = addr;
      req_wdata  = wdata;
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      req_we     = ~we;
      req_ifetch = ~ifetch;
      req_addr   = ~addr;
      req_wdata  = ~wdata;
      got = 1'b0;
      k   = 0;
      while (!got && k < 20) begin
         @(negedge clk);
         k++;
         if (resp_valid) got = 1'b1;
      end
      chk({tag, " latency"}, 32'(k), 32'(WA + 1));
      chk({tag, " err"},     32'(resp_err), 32'(exp_err));
      chk({tag, " rdata"},   resp_rdata, exp_rdata);
      @(negedge clk);
      chk({tag, " pulse"},   {resp_err, resp_valid, 30'd0} | resp_rdata, 32'd0);
      $display("txn %s we=%0d if=%0d addr=0x%08h rdata=0x%08h err=%0d lat=%0d",
               tag, we, ifetch, addr, exp_rdata, exp_err, k);
   endtask

   initial begin
      rst_n = 1'b0;
      req_valid = 1'b0; req_we = 1'b0; req_ifetch = 1'b0; req_addr = '0; req_wdata = '0;
      b_valid = 1'b0; b_we = 1'b0; b_ifetch = 1'b0; b_addr = '0; b_wdata = '0;

      repeat (2) @(negedge clk);
      chk("rst ready", 32'(req_ready), 32'd1);
      chk("rst valid", 32'(resp_valid), 32'd0);
      chk("rst err",   32'(resp_err), 32'd0);
      chk("rst rdata", resp_rdata, 32'd0);
      chk("rst instr", instr, 32'd0);
      chk("rst rdreg", readdata, 32'd0);
      rst_n = 1'b1;

      // write then read
      txn("wr10", 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF);
      txn("rd10", 1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
      chk("rd10 readdata", readdata, 32'hDEADBEEF);

      // fetch
      txn("wr20", 1'b1, 1'b0, 32'h20, 32'h8C010004, 1'b0, 32'h8C010004);
      txn("if20", 1'b0, 1'b1, 32'h20, 32'h0, 1'b0, 32'h8C010004);
      chk("if20 instr", instr, 32'h8C010004);
      chk("if20 readdata", readdata, 32'hDEADBEEF);

      // errors
      txn("wr14", 1'b1, 1'b0, 32'h14, 32'hA5A50014, 1'b0, 32'hA5A50014);
      txn("rd13", 1'b0, 1'b0, 32'h13, 32'h0, 1'b1, 32'h0);
      chk("rd13 readdata", readdata, 32'hDEADBEEF);
      txn("wf14", 1'b1, 1'b1, 32'h14, 32'hFFFF, 1'b1, 32'h0);
      chk("wf14 instr", instr, 32'h8C010004);
      txn("rd14", 1'b0, 1'b0, 32'h14, 32'h0, 1'b0, 32'hA5A50014);
      chk("rd14 readdata", readdata, 32'hA5A50014);

      // wrap modulo 256 bytes
      txn("wr104", 1'b1, 1'b0, 32'h104, 32'h1234, 1'b0, 32'h1234);
      txn("rd004", 1'b0, 1'b0, 32'h004, 32'h0, 1'b0, 32'h1234);

      // reset in WAIT aborts the write
      txn("wr08", 1'b1, 1'b0, 32'h8, 32'h1111, 1'b0, 32'h1111);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_ifetch = 1'b0;
      req_addr = 32'h8; req_wdata = 32'h5555;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      chk("abort inwait", 32'(req_ready), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("abort ready", 32'(req_ready), 32'd1);
      chk("abort valid", 32'(resp_valid), 32'd0);
      chk("abort err",   32'(resp_err), 32'd0);
      chk("abort rdata", resp_rdata, 32'd0);
      chk("abort instr", instr, 32'd0);
      chk("abort rdreg", readdata, 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("abort novalid", 32'(resp_valid), 32'd0);
      end
      rst_n = 1'b1;
      $display("txn abort write addr=0x00000008 during WAIT");
      txn("rd08", 1'b0, 1'b0, 32'h8, 32'h0, 1'b0, 32'h1111);
      chk("rd08 readdata", readdata, 32'h1111);

      // zero wait states, request held continuously
      @(negedge clk);
      b_valid = 1'b1; b_we = 1'b1; b_addr = 32'h0; b_wdata = 32'h77;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("b valid", 32'(b_resp_valid), 32'((i % 2) == 0));
         chk("b ready", 32'(b_ready), 32'((i % 2) != 0));
         chk("b rdata", b_resp_rdata, ((i % 2) == 0) ? 32'h77 : 32'h0);
         $display("txn b cycle %0d valid=%0d ready=%0d", i, b_resp_valid, b_ready);
      end
      b_we = 1'b0;
      @(negedge clk);
      chk("b rd valid", 32'(b_resp_valid), 32'd1);
      chk("b rd rdata", b_resp_rdata, 32'h77);
      b_valid = 1'b0;
      @(negedge clk);
      chk("b readdata", b_readdata, 32'h77);
      $display("txn b read addr=0x00000000 rdata=0x%08h", b_resp_rdata);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
